// File: rtl/sysid_regfile.sv
// ---------------------------------------------------------------------------
// sysid_regfile
//   Small memory-mapped system identification block: constant ID and build
//   timestamp words, a byte-writable scratch register, a free-running 64-bit
//   uptime counter with a high-word snapshot, a control register and a few
//   read-only user words supplied from outside.
//
// Ports
//   clock          sole clock, rising edge
//   reset          synchronous, active-high
//   address        word address (ADDR_W bits)
//   read           read request, accepted every cycle
//   write          write request, accepted every cycle
//   writedata      32-bit write data
//   byteenable     write byte lanes, bit n -> writedata[8n+7:8n]
//   user_words     NUM_USER packed 32-bit words, word k at [32k+31:32k]
//   readdata       registered read data, valid one cycle after the read
//   readdatavalid  one-cycle pulse per accepted read
//
// Map: 0 ID, 1 TIMESTAMP, 2 SCRATCH, 3 UPTIME_LO, 4 UPTIME_HI (snapshot),
//      5 CTRL (bit0 EN, bit1 CLR pulse), 6-7 reserved, 8.. USER[k]
// ---------------------------------------------------------------------------
module sysid_regfile #(
  parameter logic [31:0] ID_VALUE     = 32'h506B_6A9A,
  parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
  parameter logic [31:0] SCRATCH_INIT = 32'h0000_0000,
  parameter int          NUM_USER     = 2,
  parameter int          ADDR_W       = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       address,
  input  logic                    read,
  input  logic                    write,
  input  logic [31:0]             writedata,
  input  logic [3:0]              byteenable,
  input  logic [32*NUM_USER-1:0]  user_words,
  output logic [31:0]             readdata,
  output logic                    readdatavalid
);

  localparam logic [ADDR_W-1:0] A_ID      = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_TSTAMP  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_SCRATCH = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_UP_LO   = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_UP_HI   = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(5);
  localparam int                USER_BASE = 8;

  logic [31:0] scratch;
  logic        en;
  logic [63:0] uptime;
  logic [31:0] snapshot;
  logic [31:0] rdata_q;
  logic        rvalid_q;
  logic [31:0] read_mux;
  logic        wr_scratch;
  logic        wr_ctrl;
  logic        clr;

  // Read mux always reflects the pre-edge state, so a same-cycle write is
  // never visible to the read that accompanies it.
  always_comb begin
    read_mux = 32'h0;
    case (address)
      A_ID:      read_mux = ID_VALUE;
      A_TSTAMP:  read_mux = TIMESTAMP;
      A_SCRATCH: read_mux = scratch;
      A_UP_LO:   read_mux = uptime[31:0];
      A_UP_HI:   read_mux = snapshot;
      A_CTRL:    read_mux = {31'h0, en};
      default: begin
        for (int k = 0; k < NUM_USER; k++) begin
          if (address == ADDR_W'(USER_BASE + k)) begin
            read_mux = user_words[32*k +: 32];
          end
        end
      end
    endcase
  end

  assign wr_scratch = write && (address == A_SCRATCH);
  assign wr_ctrl    = write && (address == A_CTRL) && byteenable[0];
  assign clr        = wr_ctrl && writedata[1];

  always_ff @(posedge clock) begin
    if (reset) begin
      scratch  <= SCRATCH_INIT;
      en       <= 1'b1;
      uptime   <= 64'h0;
      snapshot <= 32'h0;
      rdata_q  <= 32'h0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= read;
      if (read) begin
        rdata_q <= read_mux;
      end
      // Reading the low word freezes the matching high word so software
      // gets a coherent 64-bit value from two reads.
      if (read && (address == A_UP_LO)) begin
        snapshot <= uptime[63:32];
      end
      for (int b = 0; b < 4; b++) begin
        if (wr_scratch && byteenable[b]) begin
          scratch[8*b +: 8] <= writedata[8*b +: 8];
        end
      end
      if (wr_ctrl) begin
        en <= writedata[0];
      end
      // Increment uses the EN value from before this edge's CTRL write.
      if (clr) begin
        uptime <= 64'h0;
      end else if (en) begin
        uptime <= uptime + 64'd1;
      end
    end
  end

  // Outputs are masked while reset is high so a read accepted just before
  // reset never shows a valid pulse.
  assign readdatavalid = rvalid_q & ~reset;
  assign readdata      = reset ? 32'h0 : rdata_q;

endmodule

// File: tb/tb_sysid_regfile.sv
// ---------------------------------------------------------------------------
// tb_sysid_regfile
//   Self-checking bench for sysid_regfile. Inputs change just after the
//   rising edge, outputs are compared at the falling edge against a
//   behavioural register-map model, plus literal checks of known values.
// ---------------------------------------------------------------------------
module tb_sysid_regfile;

  localparam int          NUM_USER = 2;
  localparam int          ADDR_W   = 4;
  localparam logic [31:0] ID_VAL   = 32'h506B_6A9A;
  localparam logic [31:0] TS_VAL   = 32'h0000_0000;
  localparam logic [31:0] SI_VAL   = 32'h0000_0000;

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  logic [ADDR_W-1:0]      address = '0;
  logic                   read = 1'b0;
  logic                   write = 1'b0;
  logic [31:0]            writedata = '0;
  logic [3:0]             byteenable = '0;
  logic [32*NUM_USER-1:0] user_words = '0;
  logic [31:0]            readdata;
  logic                   readdatavalid;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  sysid_regfile #(
    .ID_VALUE(ID_VAL), .TIMESTAMP(TS_VAL), .SCRATCH_INIT(SI_VAL),
    .NUM_USER(NUM_USER), .ADDR_W(ADDR_W)
  ) dut (
    .clock(clock), .reset(reset), .address(address), .read(read),
    .write(write), .writedata(writedata), .byteenable(byteenable),
    .user_words(user_words), .readdata(readdata),
    .readdatavalid(readdatavalid)
  );

  // Behavioural model of the register map
  logic [31:0] m_scratch = SI_VAL;
  logic        m_en      = 1'b1;
  logic [63:0] m_cnt     = 64'h0;
  logic [31:0] m_snap    = 32'h0;
  logic [31:0] m_rd      = 32'h0;
  logic        m_rdv     = 1'b0;
  logic        m_old_en;
  logic        m_clr;
  logic [31:0] m_mask;

  function automatic logic [31:0] model_read(input int a);
    if (a == 0) return ID_VAL;
    if (a == 1) return TS_VAL;
    if (a == 2) return m_scratch;
    if (a == 3) return m_cnt[31:0];
    if (a == 4) return m_snap;
    if (a == 5) return {31'h0, m_en};
    if (a >= 8 && a < 8 + NUM_USER) return user_words[32*(a-8) +: 32];
    return 32'h0;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_scratch = SI_VAL;
      m_en      = 1'b1;
      m_cnt     = 64'h0;
      m_snap    = 32'h0;
      m_rd      = 32'h0;
      m_rdv     = 1'b0;
    end else begin
      m_rdv = read;
      if (read) m_rd = model_read(int'(address));
      if (read && int'(address) == 3) m_snap = m_cnt[63:32];
      m_mask = {{8{byteenable[3]}}, {8{byteenable[2]}},
                {8{byteenable[1]}}, {8{byteenable[0]}}};
      if (write && int'(address) == 2)
        m_scratch = (m_scratch & ~m_mask) | (writedata & m_mask);
      m_old_en = m_en;
      m_clr    = 1'b0;
      if (write && int'(address) == 5 && byteenable[0]) begin
        m_en  = writedata[0];
        m_clr = writedata[1];
      end
      m_cnt = m_clr ? 64'h0 : m_cnt + {63'h0, m_old_en};
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clock) begin
    checks++;
    if (readdatavalid !== (m_rdv && !reset)) begin
      failures++;
      $display("[TB] FAIL rdv t=%0t got=%b exp=%b", $time, readdatavalid, m_rdv && !reset);
    end
    checks++;
    if (readdata !== (reset ? 32'h0 : m_rd)) begin
      failures++;
      $display("[TB] FAIL readdata t=%0t got=%h exp=%h", $time, readdata, reset ? 32'h0 : m_rd);
    end
  end

  task automatic apply_stimulus(input logic rd, input logic wr, input int a,
                                input logic [31:0] wd, input logic [3:0] be);
    @(posedge clock);
    #1;
    read       = rd;
    write      = wr;
    address    = ADDR_W'(a);
    writedata  = wd;
    byteenable = be;
  endtask

  task automatic idle();
    apply_stimulus(1'b0, 1'b0, 0, 32'h0, 4'h0);
  endtask

  task automatic do_read(input int a);
    apply_stimulus(1'b1, 1'b0, a, 32'h0, 4'h0);
  endtask

  // Checks the outputs in the current cycle against hand-computed literals
  task automatic check_output(input string name, input logic exp_v, input logic [31:0] exp_d);
    @(negedge clock);
    #1;
    checks++;
    if (readdatavalid !== exp_v || (exp_v && readdata !== exp_d)) begin
      failures++;
      $display("[TB] FAIL %s got v=%b d=%h exp v=%b d=%h", name, readdatavalid, readdata, exp_v, exp_d);
    end
  endtask

  initial begin
    // Reads during reset are discarded
    reset = 1'b1;
    do_read(0);
    do_read(3);
    check_output("reset_state", 1'b0, 32'h0);
    idle();

    // First cycle out of reset: counter 0, then 1
    apply_stimulus(1'b1, 1'b0, 3, 32'h0, 4'h0);
    reset = 1'b0;
    do_read(3);
    check_output("uptime_first", 1'b1, 32'h0);
    do_read(0);
    check_output("uptime_second", 1'b1, 32'h1);
    do_read(1);
    check_output("id", 1'b1, ID_VAL);
    do_read(7);
    check_output("timestamp", 1'b1, TS_VAL);
    idle();
    check_output("reserved", 1'b1, 32'h0);

    // Scratch partial write with same-cycle read
    apply_stimulus(1'b1, 1'b1, 2, 32'hDEAD_BEEF, 4'b0101);
    do_read(2);
    check_output("scratch_prewrite", 1'b1, 32'h0);
    apply_stimulus(1'b0, 1'b1, 2, 32'hFFFF_FFFF, 4'b0000);
    check_output("scratch_bytes", 1'b1, 32'h00AD_00EF);
    do_read(2);
    idle();
    check_output("scratch_be0", 1'b1, 32'h00AD_00EF);

    // User words and first unmapped address
    user_words = {32'h2222_2222, 32'h1111_1111};
    do_read(8);
    do_read(9);
    check_output("user0", 1'b1, 32'h1111_1111);
    do_read(10);
    check_output("user1", 1'b1, 32'h2222_2222);
    apply_stimulus(1'b0, 1'b1, 9, 32'h1234_5678, 4'hF);
    check_output("unmapped", 1'b1, 32'h0);

    // Disable counting, counter must hold
    apply_stimulus(1'b0, 1'b1, 5, 32'h0, 4'h1);
    do_read(5);
    do_read(3);
    check_output("ctrl_en0", 1'b1, 32'h0);
    repeat (10) idle();
    do_read(3);

    // Preload counter just below a 32-bit carry while counting is stopped
    idle();
    force dut.uptime = 64'h0000_0001_FFFF_FFFF;
    m_cnt = 64'h0000_0001_FFFF_FFFF;
    idle();
    release dut.uptime;
    do_read(3);
    do_read(4);
    check_output("uptime_lo_pre", 1'b1, 32'hFFFF_FFFF);
    apply_stimulus(1'b0, 1'b1, 5, 32'h1, 4'h1);
    check_output("snapshot", 1'b1, 32'h0000_0001);
    repeat (5) idle();
    do_read(4);
    idle();
    check_output("snapshot_hold", 1'b1, 32'h0000_0001);

    // CLR pulse
    apply_stimulus(1'b0, 1'b1, 5, 32'h2, 4'h1);
    do_read(3);
    do_read(5);
    check_output("clr", 1'b1, 32'h0);
    idle();
    check_output("ctrl_clr_read", 1'b1, 32'h0);

    // 64-bit wrap
    idle();
    force dut.uptime = 64'hFFFF_FFFF_FFFF_FFFF;
    m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    idle();
    release dut.uptime;
    apply_stimulus(1'b0, 1'b1, 5, 32'h1, 4'h1);
    do_read(3);
    do_read(3);
    check_output("wrap_pre", 1'b1, 32'hFFFF_FFFF);
    do_read(4);
    check_output("wrap_post", 1'b1, 32'h0);
    idle();
    check_output("wrap_snap", 1'b1, 32'h0);

    // Reset right after a read
    do_read(0);
    apply_stimulus(1'b0, 1'b0, 0, 32'h0, 4'h0);
    reset = 1'b1;
    check_output("reset_kill", 1'b0, 32'h0);
    apply_stimulus(1'b1, 1'b0, 2, 32'h0, 4'h0);
    reset = 1'b0;
    do_read(5);
    check_output("scratch_after_reset", 1'b1, SI_VAL);
    idle();
    check_output("ctrl_after_reset", 1'b1, 32'h1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) writedata[1] = 1'b0;
      user_words = {$urandom, $urandom};
      reset = ($urandom_range(0, 63) == 0);
    end
    reset = 1'b0;
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
